// File: rtl/pong_pkg.sv
// Shared definitions for the pong game-sequencing controller.
// Holds the fixed state codes, the default game constants and a small
// helper used to size the frame counter.
package pong_pkg;

  // State codes are visible on state_o and used by the display logic,
  // so the encoding is fixed and must not be re-optimised.
  typedef enum logic [2:0] {
    PS_IDLE  = 3'd0,
    PS_SERVE = 3'd1,
    PS_PLAY  = 3'd2,
    PS_POINT = 3'd3,
    PS_OVER  = 3'd4,
    PS_PAUSE = 3'd5
  } pong_state_e;

  localparam int DEF_SCORE_W      = 4;
  localparam int DEF_WIN_SCORE    = 9;
  localparam int DEF_SERVE_FRAMES = 60;
  localparam int DEF_POINT_FRAMES = 90;

  // Larger of two integers, used for elaboration-time sizing only.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// 1-bit rising-edge detector.
// The history bit is registered; the rise flag is combinational from the
// current input and the history so the consumer reacts on the same edge
// that samples the input high for the first time.
module rise_detect (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic rise_o
);

  logic prev_q;

  // Remember last sample; history is 0 out of reset so a level already
  // high at reset release counts as one edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= d_i;
    end
  end

  assign rise_o = d_i & ~prev_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// Game-sequencing controller for the pong board.
// Decides when the ball is held at centre, served or frozen, keeps both
// scores and detects game over. All pacing is counted in video frames.
//
// Optional feature: define PONG_PAUSE_EN to add the pause_i key and the
// PAUSE state. Without it the port does not exist and PAUSE is unreachable.
//
// Interface protocol: frame_tick_i and miss_*_i are single-cycle pulses
// that are acted on only in the cycle they are high; start_i/pause_i are
// synchronised levels whose rising edges are the commands. There is no
// back-pressure: every output is registered and reflects the decision
// made on the edge that sampled the triggering input.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int SCORE_W      = DEF_SCORE_W,
  parameter int WIN_SCORE    = DEF_WIN_SCORE,
  parameter int SERVE_FRAMES = DEF_SERVE_FRAMES,
  parameter int POINT_FRAMES = DEF_POINT_FRAMES
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               frame_tick_i,
  input  logic               start_i,
`ifdef PONG_PAUSE_EN
  input  logic               pause_i,
`endif
  input  logic               miss_left_i,
  input  logic               miss_right_i,
  output logic               ball_rst_o,
  output logic               ball_run_o,
  output logic               serve_dir_o,
  output logic [SCORE_W-1:0] score_l_o,
  output logic [SCORE_W-1:0] score_r_o,
  output logic               game_over_o,
  output logic               winner_o,
  output logic [2:0]         state_o
);

  localparam logic [2:0] ST_IDLE  = PS_IDLE;
  localparam logic [2:0] ST_SERVE = PS_SERVE;
  localparam logic [2:0] ST_PLAY  = PS_PLAY;
  localparam logic [2:0] ST_POINT = PS_POINT;
  localparam logic [2:0] ST_OVER  = PS_OVER;
  localparam logic [2:0] ST_PAUSE = PS_PAUSE;

  localparam int MAX_FRAMES = max_int(SERVE_FRAMES, POINT_FRAMES);
  localparam int CNT_W      = $clog2(MAX_FRAMES + 1);

  // Counter value seen on the tick that completes each wait.
  localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [CNT_W-1:0]   POINT_LAST = CNT_W'(POINT_FRAMES - 1);
  localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);

  logic [2:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [SCORE_W-1:0] score_l_q, score_r_q;
  logic               ball_rst_q, ball_run_q, serve_dir_q;
  logic               game_over_q, winner_q;

  logic start_rise;
  logic pause_rise;
  logic cnt_inc;
  logic clr_scores;
  logic point_l;
  logic point_r;
  logic left_at_win;
  logic right_at_win;

  rise_detect u_start_rise (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .d_i    (start_i),
    .rise_o (start_rise)
  );

`ifdef PONG_PAUSE_EN
  rise_detect u_pause_rise (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .d_i    (pause_i),
    .rise_o (pause_rise)
  );
`else
  assign pause_rise = 1'b0;
`endif

  assign left_at_win  = (score_l_q == WIN_VAL);
  assign right_at_win = (score_r_q == WIN_VAL);

  // Next-state and event decode; all side effects are flags consumed by
  // the register block below.
  always_comb begin
    state_d    = state_q;
    cnt_inc    = 1'b0;
    clr_scores = 1'b0;
    point_l    = 1'b0;
    point_r    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_rise) begin
          state_d    = ST_SERVE;
          clr_scores = 1'b1;
        end
      end
      ST_SERVE: begin
        if (frame_tick_i) begin
          if (cnt_q == SERVE_LAST) begin
            state_d = ST_PLAY;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      ST_PLAY: begin
        // A left miss wins a simultaneous pair; misses beat a pause edge.
        if (miss_left_i) begin
          point_r = 1'b1;
          state_d = ST_POINT;
        end else if (miss_right_i) begin
          point_l = 1'b1;
          state_d = ST_POINT;
        end else if (pause_rise) begin
          state_d = ST_PAUSE;
        end
      end
      ST_POINT: begin
        if (frame_tick_i) begin
          if (cnt_q == POINT_LAST) begin
            state_d = (left_at_win || right_at_win) ? ST_OVER : ST_SERVE;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      ST_OVER: begin
        if (start_rise) begin
          state_d    = ST_SERVE;
          clr_scores = 1'b1;
        end
      end
      ST_PAUSE: begin
        if (pause_rise) begin
          state_d = ST_PLAY;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register and frame counter; the counter restarts on every
  // state change so each wait begins from zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q) begin
        cnt_q <= '0;
      end else if (cnt_inc) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Scores saturate at the winning value and are cleared by a new game.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      score_l_q <= '0;
      score_r_q <= '0;
    end else if (clr_scores) begin
      score_l_q <= '0;
      score_r_q <= '0;
    end else begin
      if (point_l && !left_at_win) begin
        score_l_q <= score_l_q + 1'b1;
      end
      if (point_r && !right_at_win) begin
        score_r_q <= score_r_q + 1'b1;
      end
    end
  end

  // Serve direction goes towards the player who just conceded the point
  // being served at: a left miss serves left, a right miss serves right.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      serve_dir_q <= 1'b1;
    end else if (point_r) begin
      serve_dir_q <= 1'b0;
    end else if (point_l) begin
      serve_dir_q <= 1'b1;
    end
  end

  // Ball and game-status outputs are decoded from the next state so they
  // change on the same edge as the state itself.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ball_rst_q  <= 1'b1;
      ball_run_q  <= 1'b0;
      game_over_q <= 1'b0;
      winner_q    <= 1'b0;
    end else begin
      ball_rst_q  <= (state_d == ST_IDLE) || (state_d == ST_SERVE) ||
                     (state_d == ST_OVER);
      ball_run_q  <= (state_d == ST_PLAY);
      game_over_q <= (state_d == ST_OVER);
      if ((state_d == ST_OVER) && (state_q != ST_OVER)) begin
        winner_q <= right_at_win;
      end
    end
  end

  assign state_o     = state_q;
  assign ball_rst_o  = ball_rst_q;
  assign ball_run_o  = ball_run_q;
  assign serve_dir_o = serve_dir_q;
  assign score_l_o   = score_l_q;
  assign score_r_o   = score_r_q;
  assign game_over_o = game_over_q;
  assign winner_o    = winner_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Testbench for pong_game_ctrl: directed walk through a full game, then
// randomized play checked every cycle against a behavioural game model.
// Honours PONG_PAUSE_EN for the optional pause key.
module tb_pong_game_ctrl;

  localparam int SCORE_W      = 4;
  localparam int WIN_SCORE    = 2;
  localparam int SERVE_FRAMES = 3;
  localparam int POINT_FRAMES = 4;

`ifdef PONG_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  // Game phases by their display code.
  localparam int S_IDLE  = 0;
  localparam int S_SERVE = 1;
  localparam int S_PLAY  = 2;
  localparam int S_POINT = 3;
  localparam int S_OVER  = 4;
  localparam int S_PAUSE = 5;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  logic frame_tick_i = 1'b0;
  logic start_i = 1'b0;
  logic pause_i = 1'b0;
  logic miss_left_i = 1'b0;
  logic miss_right_i = 1'b0;
  logic ball_rst_o, ball_run_o, serve_dir_o, game_over_o, winner_o;
  logic [SCORE_W-1:0] score_l_o, score_r_o;
  logic [2:0] state_o;

  always #5 clk_i = ~clk_i;

  pong_game_ctrl #(
    .SCORE_W      (SCORE_W),
    .WIN_SCORE    (WIN_SCORE),
    .SERVE_FRAMES (SERVE_FRAMES),
    .POINT_FRAMES (POINT_FRAMES)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .frame_tick_i (frame_tick_i),
    .start_i      (start_i),
`ifdef PONG_PAUSE_EN
    .pause_i      (pause_i),
`endif
    .miss_left_i  (miss_left_i),
    .miss_right_i (miss_right_i),
    .ball_rst_o   (ball_rst_o),
    .ball_run_o   (ball_run_o),
    .serve_dir_o  (serve_dir_o),
    .score_l_o    (score_l_o),
    .score_r_o    (score_r_o),
    .game_over_o  (game_over_o),
    .winner_o     (winner_o),
    .state_o      (state_o)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_phase;
  int m_frames_left;
  int m_left, m_right;
  bit m_dir, m_over, m_win;
  bit m_start_prev, m_pause_prev;

  task automatic model_reset();
    m_phase       = S_IDLE;
    m_frames_left = 0;
    m_left        = 0;
    m_right       = 0;
    m_dir         = 1'b1;
    m_over        = 1'b0;
    m_win         = 1'b0;
    m_start_prev  = 1'b0;
    m_pause_prev  = 1'b0;
  endtask

  task automatic new_game();
    m_left        = 0;
    m_right       = 0;
    m_over        = 1'b0;
    m_phase       = S_SERVE;
    m_frames_left = SERVE_FRAMES;
  endtask

  // One clock edge of game rules, given the inputs sampled on that edge.
  task automatic model_step(input bit st, input bit tk, input bit ml, input bit mr, input bit pz);
    bit s_edge, p_edge;
    s_edge = st && !m_start_prev;
    p_edge = PAUSE_EN && pz && !m_pause_prev;
    m_start_prev = st;
    m_pause_prev = pz;
    case (m_phase)
      S_IDLE, S_OVER: if (s_edge) new_game();
      S_SERVE: begin
        if (tk) m_frames_left--;
        if (m_frames_left == 0) m_phase = S_PLAY;
      end
      S_PLAY: begin
        if (ml) begin
          if (m_right < WIN_SCORE) m_right++;
          m_dir = 1'b0;
          m_phase = S_POINT;
          m_frames_left = POINT_FRAMES;
        end else if (mr) begin
          if (m_left < WIN_SCORE) m_left++;
          m_dir = 1'b1;
          m_phase = S_POINT;
          m_frames_left = POINT_FRAMES;
        end else if (p_edge) begin
          m_phase = S_PAUSE;
        end
      end
      S_POINT: begin
        if (tk) m_frames_left--;
        if (m_frames_left == 0) begin
          if (m_left == WIN_SCORE || m_right == WIN_SCORE) begin
            m_phase = S_OVER;
            m_over  = 1'b1;
            m_win   = (m_right == WIN_SCORE);
          end else begin
            m_phase = S_SERVE;
            m_frames_left = SERVE_FRAMES;
          end
        end
      end
      S_PAUSE: if (p_edge) m_phase = S_PLAY;
      default: m_phase = S_IDLE;
    endcase
  endtask

  task automatic compare_all();
    check("state", 32'(state_o), 32'(m_phase));
    check("ball_rst", 32'(ball_rst_o),
          32'(m_phase == S_IDLE || m_phase == S_SERVE || m_phase == S_OVER));
    check("ball_run", 32'(ball_run_o), 32'(m_phase == S_PLAY));
    check("serve_dir", 32'(serve_dir_o), 32'(m_dir));
    check("score_l", 32'(score_l_o), 32'(m_left));
    check("score_r", 32'(score_r_o), 32'(m_right));
    check("game_over", 32'(game_over_o), 32'(m_over));
    if (m_over) check("winner", 32'(winner_o), 32'(m_win));
  endtask

  // ---------------- driver tasks ----------------
  // Called at a falling edge: drive, clock once, check at next falling edge.
  task automatic cycle(input bit st, input bit tk, input bit ml, input bit mr, input bit pz);
    start_i      = st;
    frame_tick_i = tk;
    miss_left_i  = ml;
    miss_right_i = mr;
    pause_i      = pz;
    @(posedge clk_i);
    model_step(st, tk, ml, mr, pz);
    @(negedge clk_i);
    compare_all();
  endtask

  // Called at a falling edge: pulse reset entirely within the low phase.
  task automatic reset_dut();
    rst_i = 1'b1;
    model_reset();
    #1;
    compare_all();
    #1;
    rst_i = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  bit r_start, r_pause;

  initial begin
    model_reset();
    @(negedge clk_i);
    reset_dut();

    repeat (10) cycle(0, 0, 0, 0, 0);
    check("idle_state", 32'(state_o), 32'd0);
    check("idle_ball_rst", 32'(ball_rst_o), 32'd1);
    check("idle_ball_run", 32'(ball_run_o), 32'd0);
    check("idle_dir", 32'(serve_dir_o), 32'd1);
    check("idle_scores", 32'({score_l_o, score_r_o}), 32'd0);

    cycle(1, 0, 0, 0, 0);
    check("start_to_serve", 32'(state_o), 32'd1);
    cycle(1, 1, 0, 0, 0); cycle(1, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0); cycle(1, 0, 0, 0, 0);
    check("serve_before_third", 32'(state_o), 32'd1);
    cycle(1, 1, 0, 0, 0);
    check("serve_to_play", 32'(state_o), 32'd2);
    check("play_ball_run", 32'(ball_run_o), 32'd1);
    cycle(1, 0, 0, 0, 0);
    check("held_start_no_reentry", 32'(state_o), 32'd2);

    cycle(1, 0, 0, 1, 0);
    check("miss_r_score_l", 32'(score_l_o), 32'd1);
    check("miss_r_dir", 32'(serve_dir_o), 32'd1);
    check("miss_r_point", 32'(state_o), 32'd3);
    repeat (4) cycle(1, 1, 0, 0, 0);
    check("point_to_serve", 32'(state_o), 32'd1);
    repeat (3) cycle(1, 1, 0, 0, 0);

    cycle(1, 0, 1, 1, 0);
    check("both_score_r", 32'(score_r_o), 32'd1);
    check("both_score_l", 32'(score_l_o), 32'd1);
    check("both_dir", 32'(serve_dir_o), 32'd0);
    repeat (4) cycle(1, 1, 0, 0, 0);
    repeat (3) cycle(1, 1, 0, 0, 0);

    cycle(1, 0, 0, 1, 0);
    repeat (4) cycle(1, 1, 0, 0, 0);
    check("over_state", 32'(state_o), 32'd4);
    check("over_flag", 32'(game_over_o), 32'd1);
    check("over_winner_left", 32'(winner_o), 32'd0);
    cycle(0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    check("restart_state", 32'(state_o), 32'd1);
    check("restart_scores", 32'({score_l_o, score_r_o}), 32'd0);
    check("restart_over_clr", 32'(game_over_o), 32'd0);
    repeat (3) cycle(1, 1, 0, 0, 0);

    if (PAUSE_EN) begin
      cycle(1, 0, 0, 0, 1);
      check("pause_enter", 32'(state_o), 32'd5);
      cycle(1, 0, 1, 0, 1);
      check("pause_miss_ignored", 32'(score_r_o), 32'd0);
      cycle(1, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 1);
      check("pause_exit", 32'(state_o), 32'd2);
    end

    cycle(1, 0, 1, 0, 0);
    cycle(1, 1, 0, 0, 0);
    reset_dut();
    check("reset_in_point_state", 32'(state_o), 32'd0);
    check("reset_in_point_scores", 32'({score_l_o, score_r_o}), 32'd0);

    // Randomized play: levels toggle occasionally, pulses are sparse.
    r_start = 1'b0;
    r_pause = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 499) == 0) reset_dut();
      if ($urandom_range(0, 7) == 0) r_start = ~r_start;
      if ($urandom_range(0, 9) == 0) r_pause = ~r_pause;
      cycle(r_start,
            $urandom_range(0, 2) == 0,
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 9) == 0,
            r_pause);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
